mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Execute-stage multiply/divide unit: the responder for the decoder's `mdstart`, `mdop`, `hlwrite`, `hlsel` and `hlread` controls. It latches operands on a start, stays busy for a fixed multi-cycle latency, then commits results to HI/LO. It also services `mthi`/`mtlo` writes and supplies HI or LO to `mfhi`/`mflo`. The stall unit uses `busy` (together with `start`) to hold MDU instructions in D.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu
- `DIV_CYCLES`, 10, busy cycles for div/divu
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: decoded `mdstart` in E
- `mdop` in 3: 000 mult, 001 multu, 010 div, 011 divu; other codes are treated as multu
- `hlwrite` in 1: `mthi`/`mtlo` in E
- `hlsel` in 1: 0 selects HI, 1 selects LO, for both read and write
- `req` in 1: exception/interrupt request this cycle; suppresses `start` and `hlwrite`
- `rs_val` in 32: forwarded rs
- `rt_val` in 32: forwarded rt
- `busy` out 1: operation in flight
- `hl_out` out 32: `hlsel ? LO : HI`, combinational

## Operation
- States: IDLE, BUSY. `cnt` is a latency down-counter.
- IDLE with `start & !req`:
  - latch `rs_val`, `rt_val` and `mdop`;
  - load `cnt` = `MULT_CYCLES` or `DIV_CYCLES`;
  - go to BUSY.
- BUSY:
  - `cnt` decrements each cycle.
  - On the cycle with `cnt == 1`, write results to HI/LO and return to IDLE.
- `hlwrite & !req & !busy & !start` writes `rs_val` to HI or LO, selected by `hlsel`.
- Priority:
  - `start` wins over `hlwrite`.
  - `start` or `hlwrite` while BUSY is ignored. The pipeline never issues these; the bench asserts this.
- `req` does not abort an in-flight operation; that instruction has already passed E.
- Arithmetic:
  - mult/multu: full 64-bit product, HI = [63:32], LO = [31:0].
  - div: quotient truncates toward zero, remainder takes the dividend's sign.
  - div overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero: see Configuration.
- Reset values: HI = 0, LO = 0, `cnt` = 0, state IDLE, `busy` = 0.
- Reset mid-operation discards the operation; HI/LO return to 0.

## Timing
- Start accepted at edge T0. `busy` is 1 for exactly N cycles after T0, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO update at edge T0+N, the same edge where `busy` falls. `hl_out` shows the new values in cycle T0+N.
- `busy` is 0 in the cycle `start` is sampled. The stall logic therefore uses `start | busy`.
- `mthi`/`mtlo` commit at the next edge. An `mfhi`/`mflo` in the following cycle sees the new value.
- Back-to-back: a new `start` may be accepted in the cycle immediately after `busy` falls.

## Configuration
- `MDU_DIVZERO_HOLD_EN`:
  - Defined: div or divu with rt = 0 runs the full latency, then leaves HI and LO unchanged.
  - Undefined: HI = dividend and LO = 0xFFFFFFFF, for both signed and unsigned divide.
  - Neither setting produces X.

## Structure
- `mdu_pkg` holds:
  - `mdop` encodings (MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU);
  - default latencies;
  - state encodings.
- Sub-module `mdu_div32`: combinational signed/unsigned quotient and remainder, with the overflow and divide-by-zero cases, under the macro. The top level holds the FSM, counter, operand latches and HI/LO.

## Test plan
- mult rs = 0xFFFFFFFF, rt = 0x00000002 -> `busy` high for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. multu with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE.
- div rs = 0xFFFFFFF9, rt = 2 -> `busy` high for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu with the same operands -> LO = 0x7FFFFFFC, HI = 0x00000001.
- div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. div 5 / 0 -> HI = 5, LO = 0xFFFFFFFF with the macro off; HI/LO unchanged with the macro on.
- `start` together with `req` -> `busy` stays 0 and HI/LO are unchanged. mtlo 0x12345678 with `req` = 0, then mflo -> `hl_out` = 0x12345678 the next cycle.
- Start mult, then pulse `rst_n` low at cycle 3 -> `busy` = 0 and HI = LO = 0 immediately, state IDLE. A new mult started after reset completes normally.
- `start` on the cycle `busy` falls -> accepted; the second result is correct. `hlwrite` during BUSY -> ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings, latencies and helpers for the execute-stage multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDOP_MULT  = 3'b000;
    localparam logic [2:0] MDOP_MULTU = 3'b001;
    localparam logic [2:0] MDOP_DIV   = 3'b010;
    localparam logic [2:0] MDOP_DIVU  = 3'b011;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_DIV);
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Decoder/pipeline-to-MDU control and operand bundle.
interface mdu_if;
    logic        start;
    logic [2:0]  mdop;
    logic        hlwrite;
    logic        hlsel;
    logic        req;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hl_out;

    modport master (output start, mdop, hlwrite, hlsel, req, rs_val, rt_val,
                    input  busy, hl_out);
    modport slave  (input  start, mdop, hlwrite, hlsel, req, rs_val, rt_val,
                    output busy, hl_out);
endinterface

// File: rtl/mdu_div32.sv
// Combinational 32-bit signed/unsigned divider; divide-by-zero behaviour set by MDU_DIVZERO_HOLD_EN.
module mdu_div32
    import mdu_pkg::*;
(
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_signed,
    output hilo_t       o_res,
    output logic        o_wr_en
);

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_safe_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic        w_div_zero;
    logic        w_ovf;

    assign w_neg_a    = i_signed & i_dividend[31];
    assign w_neg_b    = i_signed & i_divisor[31];
    assign w_abs_a    = neg_if(i_dividend, w_neg_a);
    assign w_abs_b    = neg_if(i_divisor, w_neg_b);
    assign w_div_zero = (i_divisor == 32'd0);
    assign w_ovf      = i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);
    // A zero divisor is replaced so the divider core never yields X.
    assign w_safe_b   = w_div_zero ? 32'd1 : w_abs_b;
    assign w_q_mag    = w_abs_a / w_safe_b;
    assign w_r_mag    = w_abs_a % w_safe_b;

    always_comb begin
        o_res.lo = neg_if(w_q_mag, w_neg_a ^ w_neg_b);
        o_res.hi = neg_if(w_r_mag, w_neg_a);
        o_wr_en  = 1'b1;
        if (w_ovf) begin
            o_res.lo = 32'h8000_0000;
            o_res.hi = 32'd0;
        end else if (w_div_zero) begin
            o_res.hi = i_dividend;
            o_res.lo = 32'hFFFF_FFFF;
`ifdef MDU_DIVZERO_HOLD_EN
            o_wr_en  = 1'b0;
`else
            o_wr_en  = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mthi/mtlo/mfhi/mflo access.
// Divide-by-zero handling selected by MDU_DIVZERO_HOLD_EN (see mdu_div32).
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic rst_n,
    mdu_if.slave bus
);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [2:0]       r_op;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_busy;
    logic        w_accept;
    logic        w_hl_wr;
    logic        w_done;
    logic        w_sext;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    hilo_t       w_div_res;
    logic        w_div_wr;
    hilo_t       w_res;
    logic        w_res_wr;

    assign w_busy   = (r_state == ST_BUSY);
    assign w_accept = bus.start & ~bus.req & ~w_busy;
    assign w_hl_wr  = bus.hlwrite & ~bus.req & ~w_busy & ~bus.start;
    assign w_done   = w_busy && (r_cnt == CNT_W'(1));

    // Sign/zero extension lets one 64-bit multiplier serve mult and multu.
    assign w_sext  = is_signed_op(r_op);
    assign w_ext_a = {{32{w_sext & r_rs[31]}}, r_rs};
    assign w_ext_b = {{32{w_sext & r_rt[31]}}, r_rt};
    assign w_prod  = w_ext_a * w_ext_b;

    mdu_div32 u_div (
        .i_dividend (r_rs),
        .i_divisor  (r_rt),
        .i_signed   (w_sext),
        .o_res      (w_div_res),
        .o_wr_en    (w_div_wr)
    );

    assign w_res    = is_div(r_op) ? w_div_res : hilo_t'(w_prod);
    assign w_res_wr = is_div(r_op) ? w_div_wr : 1'b1;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rs <= bus.rs_val;
            r_rt <= bus.rt_val;
            r_op <= bus.mdop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_accept) begin
            r_state <= ST_BUSY;
            r_cnt   <= is_div(bus.mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (w_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_done) begin
                r_state <= ST_IDLE;
                if (w_res_wr) begin
                    r_hi <= w_res.hi;
                    r_lo <= w_res.lo;
                end
            end
        end else if (w_hl_wr) begin
            if (bus.hlsel) r_lo <= bus.rs_val;
            else           r_hi <= bus.rs_val;
        end
    end

    assign bus.busy   = w_busy;
    assign bus.hl_out = bus.hlsel ? r_lo : r_hi;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; honours MDU_DIVZERO_HOLD_EN for divide-by-zero.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mdu_if u_if ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        u_if.start   = 1'b0;
        u_if.mdop    = 3'b000;
        u_if.hlwrite = 1'b0;
        u_if.hlsel   = 1'b0;
        u_if.req     = 1'b0;
        u_if.rs_val  = 32'd0;
        u_if.rt_val  = 32'd0;
    endtask

    task automatic read_hl(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        u_if.hlsel = 1'b0;
        #1;
        checks++;
        if (u_if.hl_out !== exp_hi) begin
            errors++;
            $display("FAIL %s HI: got %h expected %h", name, u_if.hl_out, exp_hi);
        end
        u_if.hlsel = 1'b1;
        #1;
        checks++;
        if (u_if.hl_out !== exp_lo) begin
            errors++;
            $display("FAIL %s LO: got %h expected %h", name, u_if.hl_out, exp_lo);
        end
        u_if.hlsel = 1'b0;
    endtask

    // Drives one start at a negedge and returns at the negedge of the cycle busy falls.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string name);
        int cnt;
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.mdop   = op;
        u_if.rs_val = a;
        u_if.rt_val = b;
        #1;
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_start: got %b expected 0", name, u_if.busy);
        end
        @(negedge clk);
        u_if.start = 1'b0;
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, n);
        end
        read_hl(exp_hi, exp_lo, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", u_if.busy);
        end
        read_hl(32'd0, 32'd0, "reset");
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        run_op(MDOP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        run_op(MDOP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(3'b111,     32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE, "op111_as_multu");
        run_op(MDOP_MULT,  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
    endtask

    task automatic test_div();
        run_op(MDOP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(MDOP_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, "divu");
        run_op(MDOP_DIV,  32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_pos_neg");
        run_op(MDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_ovf");
`ifdef MDU_DIVZERO_HOLD_EN
        run_op(MDOP_DIV,  32'd5, 32'd0, 10, 32'h0000_0000, 32'h8000_0000, "div_by_zero");
        run_op(MDOP_DIVU, 32'd9, 32'd0, 10, 32'h0000_0000, 32'h8000_0000, "divu_by_zero");
`else
        run_op(MDOP_DIV,  32'd5, 32'd0, 10, 32'h0000_0005, 32'hFFFF_FFFF, "div_by_zero");
        run_op(MDOP_DIVU, 32'd9, 32'd0, 10, 32'h0000_0009, 32'hFFFF_FFFF, "divu_by_zero");
`endif
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.mdop   = MDOP_MULT;
        u_if.rs_val = 32'd3;
        u_if.rt_val = 32'd4;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: got %b expected 0", u_if.busy);
        end
        read_hl(32'd0, 32'd0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MDOP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12, "mult_after_reset");
    endtask

    task automatic test_req_and_hlwrite();
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.req    = 1'b1;
        u_if.mdop   = MDOP_MULTU;
        u_if.rs_val = 32'hFFFF_FFFF;
        u_if.rt_val = 32'hFFFF_FFFF;
        @(negedge clk);
        u_if.start = 1'b0;
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_req_busy: got %b expected 0", u_if.busy);
        end
        u_if.hlwrite = 1'b1;
        u_if.hlsel   = 1'b1;
        @(negedge clk);
        u_if.hlwrite = 1'b0;
        u_if.req     = 1'b0;
        read_hl(32'd0, 32'd12, "req_suppress");
        u_if.hlwrite = 1'b1;
        u_if.hlsel   = 1'b1;
        u_if.rs_val  = 32'h1234_5678;
        @(negedge clk);
        u_if.hlwrite = 1'b0;
        u_if.hlsel   = 1'b1;
        #1;
        checks++;
        if (u_if.hl_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mtlo_mflo: got %h expected 12345678", u_if.hl_out);
        end
        u_if.hlwrite = 1'b1;
        u_if.hlsel   = 1'b0;
        u_if.rs_val  = 32'hCAFE_F00D;
        @(negedge clk);
        u_if.hlwrite = 1'b0;
        read_hl(32'hCAFE_F00D, 32'h1234_5678, "mthi_mfhi");
    endtask

    task automatic test_back_to_back();
        int cnt;
        run_op(MDOP_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd42, "b2b_first");
        u_if.start  = 1'b1;
        u_if.mdop   = MDOP_DIVU;
        u_if.rs_val = 32'd100;
        u_if.rt_val = 32'd7;
        @(negedge clk);
        u_if.start   = 1'b0;
        u_if.hlwrite = 1'b1;
        u_if.hlsel   = 1'b0;
        u_if.rs_val  = 32'hDEAD_BEEF;
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 3) u_if.hlwrite = 1'b0;
            @(negedge clk);
        end
        u_if.hlwrite = 1'b0;
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL b2b_second_busy_cycles: got %0d expected 10", cnt);
        end
        read_hl(32'd2, 32'd14, "b2b_second");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_div();
        test_mid_reset();
        test_req_and_hlwrite();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
